// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between an MMIO UART peripheral and a UART core transmitter.
// Bytes pushed by the peripheral are queued and launched one at a time into the core.
// Each launch is a one-cycle tx_ena strobe. The next byte waits until the core has
// raised and then dropped tx_busy. If tx_busy never rises, a timeout lets the FIFO move on.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   wr_en    in   push request
//   wr_data  in   byte to push
//   flush    in   discard all queued (not yet launched) bytes
//   clr_ovf  in   clear the sticky overflow flag
//   full     out  level == 2**DEPTH_BITS
//   empty    out  level == 0
//   level    out  bytes queued, excluding the in-flight byte
//   overflow out  sticky: a push was rejected
//   tx_data  out  byte presented to the UART core
//   tx_ena   out  one-cycle launch strobe
//   tx_busy  in   UART core transmitter busy
//   drained  out  one-cycle pulse: last transmission ended with nothing queued
module uart_tx_fifo #(
    parameter int unsigned DEPTH_BITS   = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                flush,
    input  logic                clr_ovf,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_BITS:0] level,
    output logic                overflow,
    output logic [7:0]          tx_data,
    output logic                tx_ena,
    input  logic                tx_busy,
    output logic                drained
);

    localparam int unsigned Depth  = 2 ** DEPTH_BITS;
    localparam int unsigned LvlW   = DEPTH_BITS + 1;
    localparam int unsigned TimerW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    // Storage has no reset so it can map onto block or distributed RAM.
    logic [7:0] mem [Depth];

    state_e                state_q, state_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic                  drained_q, drained_d;

    logic push_acc;
    logic pop;
    logic tx_end;

    assign full     = (level_q == LvlW'(Depth));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_ena   = (state_q == StLaunch);
    assign drained  = drained_q;

    // Pointer, level and overflow bookkeeping.
    always_comb begin
        // A flush frees the whole FIFO before the push is considered, so a
        // push together with a flush is always kept.
        push_acc   = wr_en && (!full || flush);
        pop        = (state_q == StIdle) && !empty && !tx_busy;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
            level_d  = level_q - LvlW'(1);
        end

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
            level_d  = level_d + LvlW'(1);
        end

        // A rejected push in the same cycle as a clear wins.
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (wr_en && !push_acc) begin
            overflow_d = 1'b1;
        end
    end

    // Launch FSM.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        tx_end    = 1'b0;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d   = StLaunch;
                    tx_data_d = mem[rd_ptr_q];
                end
            end
            StLaunch: begin
                state_d = StWaitBusy;
                timer_d = '0;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerW'(BUSY_TIMEOUT - 1)) begin
                    // Core never acknowledged; give up rather than deadlock.
                    state_d = StIdle;
                    tx_end  = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                    tx_end  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // level_d is zero only when nothing remains and no push was accepted.
        drained_d = tx_end && (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timer_q    <= '0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
            drained_q  <= drained_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int unsigned DepthBits = 4;
    localparam int unsigned Depth     = 16;
    localparam int unsigned Timeout   = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_ena;
    logic       tx_busy;
    logic       drained;

    logic tb_busy;
    logic model_mode;
    logic model_busy;
    int   model_cnt = 0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_launch = 0;
    int n_drained = 0;

    logic [7:0] exp_q[$];
    int         launch_cyc[$];

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       flush;
        logic       clr_ovf;
        logic [4:0] exp_level;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    uart_tx_fifo #(
        .DEPTH_BITS  (DepthBits),
        .BUSY_TIMEOUT(Timeout)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .flush   (flush),
        .clr_ovf (clr_ovf),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .overflow(overflow),
        .tx_data (tx_data),
        .tx_ena  (tx_ena),
        .tx_busy (tx_busy),
        .drained (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model UART core: busy rises the cycle after tx_ena and lasts 10 cycles.
    always @(posedge clk) begin
        if (tx_ena) model_cnt <= 10;
        else if (model_cnt > 0) model_cnt <= model_cnt - 1;
    end
    assign model_busy = (model_cnt > 0);
    assign tx_busy = model_mode ? model_busy : tb_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every launch must carry the next expected byte.
    always @(negedge clk) begin
        if (tx_ena) begin
            n_launch++;
            launch_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL launch_unexpected: got tx_data=%02h, expected no launch", tx_data);
            end else begin
                check("tx_data_order", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (drained) n_drained++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_sent(input string name, input int budget);
        int b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            step();
            b--;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mlev;
        int nl;
        int d0;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clr_ovf = 1'b0;
        tb_busy = 1'b0; model_mode = 1'b0;

        // Reset state
        step_n(3);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_tx_ena", tx_ena, 0);
        check("rst_drained", drained, 0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        step();

        // Single byte, launch latency and drained pulse
        push(8'hA5);
        check("single_level_after_push", level, 1);
        check("single_no_early_ena", tx_ena, 0);
        step();
        check("single_tx_ena", tx_ena, 1);
        check("single_tx_data", tx_data, 8'hA5);
        check("single_level_after_pop", level, 0);
        tb_busy = 1'b1;
        step();
        check("single_ena_one_cycle", tx_ena, 0);
        step_n(3);
        check("single_no_drained_while_busy", drained, 0);
        tb_busy = 1'b0;
        step();
        check("single_drained_pulse", drained, 1);
        step();
        check("single_drained_one_cycle", drained, 0);

        // Fill / overflow table, tx_busy held high so nothing launches
        for (int i = 0; i < 17; i++) begin
            vecs.push_back('{1'b1, 8'(i), 1'b0, 1'b0, 5'((i < 16) ? i + 1 : 16),
                             (i >= 15), 1'b0, (i == 16)});
        end
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hEE, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0});

        tb_busy = 1'b1;
        mlev = 0;
        foreach (vecs[k]) begin
            wr_en   = vecs[k].wr_en;
            wr_data = vecs[k].wr_data;
            flush   = vecs[k].flush;
            clr_ovf = vecs[k].clr_ovf;
            if (vecs[k].wr_en && mlev < Depth) begin
                exp_q.push_back(vecs[k].wr_data);
                mlev++;
            end
            step();
            check($sformatf("tbl%0d_level", k), level, vecs[k].exp_level);
            check($sformatf("tbl%0d_full", k), full, vecs[k].exp_full);
            check($sformatf("tbl%0d_empty", k), empty, vecs[k].exp_empty);
            check($sformatf("tbl%0d_overflow", k), overflow, vecs[k].exp_ovf);
            check($sformatf("tbl%0d_no_launch", k), tx_ena, 0);
        end
        wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;

        nl = n_launch;
        model_mode = 1'b1;
        wait_sent("fill_all_sent", 400);
        step_n(20);
        check("fill_launch_count", n_launch - nl, 16);
        check("fill_empty_after", empty, 1);

        // Wrap-around stream with the model core
        nl = n_launch;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) push(8'($urandom_range(0, 255)));
            step_n(110);
        end
        wait_sent("wrap_all_sent", 600);
        step_n(20);
        check("wrap_launch_count", n_launch - nl, 40);
        check("wrap_no_overflow", overflow, 0);
        check("wrap_level", level, 0);

        // Timeout: busy never rises
        model_mode = 1'b0;
        tb_busy = 1'b0;
        step();
        launch_cyc.delete();
        d0 = n_drained;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        step_n(40);
        check("timeout_launches", launch_cyc.size(), 3);
        if (launch_cyc.size() == 3) begin
            check("timeout_gap1", launch_cyc[1] - launch_cyc[0], Timeout + 2);
            check("timeout_gap2", launch_cyc[2] - launch_cyc[1], Timeout + 2);
        end
        check("timeout_drained_once", n_drained - d0, 1);

        // Flush with a byte in flight and a simultaneous push
        tb_busy = 1'b1;
        for (int k = 0; k < 6; k++) push(8'h30 + 8'(k));
        check("flush_level_6", level, 6);
        tb_busy = 1'b0;
        step();
        tb_busy = 1'b1;
        check("flush_launch_b0", tx_ena, 1);
        check("flush_b0_data", tx_data, 8'h30);
        check("flush_level_5", level, 5);
        step_n(2);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        exp_q.delete();
        exp_q.push_back(8'h77);
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_level_1", level, 1);
        check("flush_inflight_kept", tx_data, 8'h30);
        step_n(3);
        check("flush_no_launch_while_busy", tx_ena, 0);
        tb_busy = 1'b0;
        step();
        check("flush_no_drained", drained, 0);
        step();
        check("flush_next_launch", tx_ena, 1);
        check("flush_next_data", tx_data, 8'h77);
        step_n(10);
        check("flush_empty_after", empty, 1);

        // Reset in WAIT_DONE with three queued
        tb_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(8'h50 + 8'(k));
        tb_busy = 1'b0;
        step();
        tb_busy = 1'b1;
        step_n(2);
        check("rstmid_level_3", level, 3);
        rst = 1'b1;
        step();
        check("rstmid_empty", empty, 1);
        check("rstmid_level", level, 0);
        check("rstmid_tx_ena", tx_ena, 0);
        check("rstmid_overflow", overflow, 0);
        exp_q.delete();
        rst = 1'b0;
        tb_busy = 1'b0;
        nl = n_launch;
        step_n(20);
        check("rstmid_no_launch", n_launch - nl, 0);
        check("rstmid_still_empty", empty, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 4: FIFO holds 2**DEPTH_BITS bytes (16).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4: cycles allowed for tx_busy to rise after a launch.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  push request from the MMIO UART peripheral.
REQ-006 wr_data  input  8  byte to push.
REQ-007 flush  input  1  discard all queued, not-yet-launched bytes.
REQ-008 clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 full  output  1  level equals 2**DEPTH_BITS.
REQ-010 empty  output  1  level equals 0.
REQ-011 level  output  DEPTH_BITS+1  bytes queued, excluding the in-flight byte.
REQ-012 overflow  output  1  sticky flag; a push was rejected.
REQ-013 tx_data  output  8  byte to the UART core.
REQ-014 tx_ena  output  1  one-cycle launch strobe to the UART core.
REQ-015 tx_busy  input  1  UART core transmitter busy.
REQ-016 drained  output  1  one-cycle pulse when the FIFO is empty and the last transmission ends.

Function
REQ-017 SHALL accept a push when wr_en=1 and full=0 at the clock edge; the byte is written at wr_ptr, wr_ptr increments modulo 2**DEPTH_BITS, and level increments.
REQ-018 SHALL evaluate full on the registered state at the start of the cycle; a push while full SHALL be dropped and set overflow, even if a pop happens in the same cycle.
REQ-019 SHALL hold overflow until clr_ovf=1; if clr_ovf and a rejected push occur in the same cycle, overflow SHALL read 1.
REQ-020 SHALL have FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE->LAUNCH when empty=0 and tx_busy=0; the byte at rd_ptr is latched into tx_data, rd_ptr increments with wrap, and level decrements.
REQ-022 LAUNCH: tx_ena=1 for exactly this one cycle; next state is WAIT_BUSY.
REQ-023 WAIT_BUSY->WAIT_DONE when tx_busy=1; if tx_busy stays 0 for BUSY_TIMEOUT cycles, SHALL go to IDLE (no deadlock).
REQ-024 WAIT_DONE->IDLE when tx_busy=0.
REQ-025 tx_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-026 A push and a pop in the same cycle SHALL leave level unchanged and both SHALL take effect.
REQ-027 Latency: a push at edge N into an empty FIFO in IDLE with tx_busy=0 SHALL give tx_ena=1 in cycle N+1, with the byte on tx_data.
REQ-028 flush=1 SHALL set rd_ptr=wr_ptr and level=0 at the edge, and SHALL NOT alter the FSM or an in-flight byte.
REQ-029 If flush and wr_en occur in the same cycle, the flush SHALL apply first and the new byte SHALL be kept (level=1).
REQ-030 drained SHALL pulse on a WAIT_DONE->IDLE or timeout->IDLE transition when level=0 and no push is accepted that cycle.
REQ-031 Pointers SHALL be DEPTH_BITS wide; level SHALL be an independent counter of DEPTH_BITS+1 bits.
REQ-032 Storage SHALL be a synchronous-write array with no reset, so it maps to iCE40 BRAM or LUT RAM.

Reset
REQ-033 rst=1 SHALL, at the next edge, force the FSM to IDLE, pointers and level to 0, and overflow to 0.
REQ-034 After reset, empty=1, full=0, tx_ena=0, drained=0, tx_data=8'h00.
REQ-035 rst asserted mid-transmission SHALL drop tx_ena in the following cycle and discard all queued bytes; the UART core is not notified.

Verification
REQ-036 Single byte: push 8'hA5 into idle FIFO with tx_busy=0 -> tx_ena=1 and tx_data=8'hA5 one cycle later; level back to 0; drained pulses after tx_busy rises then falls.
REQ-037 Fill/overflow (DEPTH_BITS=4, tx_busy held 1): push 17 bytes 0x00..0x10 -> after 16 pushes full=1 and level=16; 17th byte dropped and overflow=1; clr_ovf -> overflow=0; release tx_busy -> output order 0x00..0x0F.
REQ-038 Wrap-around: 40 bytes streamed with a model UART (busy rises 1 cycle after tx_ena, lasts 10 cycles) -> all 40 bytes received in order, no loss, no overflow.
REQ-039 Timeout: tx_busy tied to 0, push 3 bytes -> three tx_ena strobes, each BUSY_TIMEOUT+2 cycles apart, then drained pulse.
REQ-040 Flush: 5 queued, byte 0 in flight, flush together with push of 8'h77 -> level=1; byte 0 completes; next launched byte is 8'h77.
REQ-041 Reset mid-operation: rst during WAIT_DONE with level=3 -> next cycle empty=1, level=0, tx_ena=0; no further launches after rst releases.
